axi_wr_scheduler: RTL and testbench

Write-path controller that shares one AXI4 write master port between up to NrPorts cache-subsystem requesters (I$, bypass, D$). It arbitrates AW round-robin and records the grant order so W beats follow AW order. It also keeps an ID table of outstanding writes, so each B response returns to the requester that issued it. It drives only handshakes and select indices; the enclosing subsystem muxes the AW/W payloads using `aw_sel_o`/`w_sel_o`.

---
 rtl/axi_wr_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_axi_wr_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_scheduler.sv
// Shares one AXI4 write master between NrPorts requesters: round-robin AW, AW-ordered W, ID-routed B.
// Define AXI_WR_SCHED_FALL_THROUGH_EN to make the W-order FIFO fall-through (same-cycle AW->W).
//   state     | meaning
//   AW_IDLE   | arbiter drives aw_sel; a new grant may be presented this cycle
//   AW_LOCKED | AW presented and stalled; aw_sel held in lock_sel_q until aw_ready_i
module axi_wr_scheduler #(
    parameter int NrPorts        = 3,
    parameter int IdWidth        = 4,
    parameter int MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NrPorts-1:0]                   aw_valid_i,
    input  logic [NrPorts*IdWidth-1:0]           aw_id_i,
    output logic [NrPorts-1:0]                   aw_ready_o,
    output logic                                 aw_valid_o,
    input  logic                                 aw_ready_i,
    output logic [$clog2(NrPorts)-1:0]           aw_sel_o,
    input  logic [NrPorts-1:0]                   w_valid_i,
    input  logic [NrPorts-1:0]                   w_last_i,
    output logic [NrPorts-1:0]                   w_ready_o,
    output logic                                 w_valid_o,
    input  logic                                 w_ready_i,
    output logic [$clog2(NrPorts)-1:0]           w_sel_o,
    input  logic                                 b_valid_i,
    input  logic [IdWidth-1:0]                   b_id_i,
    output logic                                 b_ready_o,
    output logic [NrPorts-1:0]                   b_valid_o,
    input  logic [NrPorts-1:0]                   b_ready_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                 b_unmatched_o
);
    localparam int SelW = $clog2(NrPorts);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int PtrW = $clog2(MaxOutstanding);

    typedef enum logic {AW_IDLE, AW_LOCKED} aw_state_e;
    aw_state_e state_q, state_d;

    logic [SelW-1:0]    rr_ptr_q, lock_sel_q, arb_sel, aw_sel;
    logic               arb_found, aw_hs;
    logic [NrPorts-1:0] eligible;

    logic [SelW-1:0] fifo_mem [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] fifo_cnt_q;
    logic            fifo_full, fifo_bypass, fifo_write, fifo_read, w_active, w_pop;
    logic [SelW-1:0] w_head;

    logic [MaxOutstanding-1:0] tbl_valid_q;
    logic [IdWidth-1:0]        tbl_id_q   [MaxOutstanding];
    logic [SelW-1:0]           tbl_port_q [MaxOutstanding];
    logic [PtrW-1:0]           tbl_age_q  [MaxOutstanding];
    logic [CntW-1:0]           tbl_cnt_q;
    logic                      tbl_full, b_match, b_free, b_unmatched_q;
    logic [PtrW-1:0]           alloc_idx, b_idx;
    logic [SelW-1:0]           b_port;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(MaxOutstanding - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign fifo_full     = (fifo_cnt_q == CntW'(MaxOutstanding));
    assign tbl_full      = (tbl_cnt_q == CntW'(MaxOutstanding));
    assign outstanding_o = tbl_cnt_q;
    assign b_unmatched_o = b_unmatched_q;

    // An ID already in flight for another port would make B routing ambiguous.
    always_comb begin
        eligible = aw_valid_i;
        for (int p = 0; p < NrPorts; p++) begin
            for (int e = 0; e < MaxOutstanding; e++) begin
                if (tbl_valid_q[e] && (tbl_id_q[e] == aw_id_i[p*IdWidth +: IdWidth])
                    && (tbl_port_q[e] != SelW'(p)))
                    eligible[p] = 1'b0;
            end
        end
    end

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int i = 0; i < NrPorts; i++) begin
            if (!arb_found && eligible[SelW'((int'(rr_ptr_q) + i) % NrPorts)]) begin
                arb_found = 1'b1;
                arb_sel   = SelW'((int'(rr_ptr_q) + i) % NrPorts);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        aw_valid_o = 1'b0;
        aw_sel     = arb_sel;
        aw_ready_o = '0;
        case (state_q)
            AW_IDLE: begin
                aw_valid_o = arb_found && !fifo_full && !tbl_full;
                if (aw_valid_o && !aw_ready_i) state_d = AW_LOCKED;
            end
            AW_LOCKED: begin
                aw_valid_o = 1'b1;
                aw_sel     = lock_sel_q;
                if (aw_ready_i) state_d = AW_IDLE;
            end
            default: state_d = AW_IDLE;
        endcase
        aw_ready_o[aw_sel] = aw_valid_o & aw_ready_i;
    end

    assign aw_hs    = aw_valid_o & aw_ready_i;
    assign aw_sel_o = aw_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= AW_IDLE;
            lock_sel_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == AW_IDLE) lock_sel_q <= arb_sel;
            if (aw_hs) rr_ptr_q <= (aw_sel == SelW'(NrPorts - 1)) ? '0 : aw_sel + 1'b1;
        end
    end

    always_comb begin
        w_active    = (fifo_cnt_q != '0);
        w_head      = fifo_mem[rd_ptr_q];
        fifo_bypass = 1'b0;
`ifdef AXI_WR_SCHED_FALL_THROUGH_EN
        if (!w_active && aw_hs) begin
            fifo_bypass = 1'b1;
            w_active    = 1'b1;
            w_head      = aw_sel;
        end
`endif
        w_sel_o   = w_active ? w_head : '0;
        w_valid_o = w_active & w_valid_i[w_sel_o];
        w_ready_o = '0;
        if (w_active) w_ready_o[w_sel_o] = w_ready_i;
        w_pop      = w_valid_o & w_ready_i & w_last_i[w_sel_o];
        // A bypassed grant whose burst also finishes this cycle never lands in the FIFO.
        fifo_write = aw_hs & !(fifo_bypass & w_pop);
        fifo_read  = w_pop & !fifo_bypass;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int e = 0; e < MaxOutstanding; e++) fifo_mem[e] <= '0;
        end else begin
            if (fifo_write) begin
                fifo_mem[wr_ptr_q] <= aw_sel;
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (fifo_read) rd_ptr_q <= ptr_inc(rd_ptr_q);
            fifo_cnt_q <= fifo_cnt_q + CntW'(fifo_write) - CntW'(fifo_read);
        end
    end

    // Ages are dense ranks 0..n-1 among live entries; the oldest match has the smallest age.
    always_comb begin
        alloc_idx = '0;
        for (int e = MaxOutstanding - 1; e >= 0; e--)
            if (!tbl_valid_q[e]) alloc_idx = PtrW'(e);
        b_match = 1'b0;
        b_idx   = '0;
        for (int e = 0; e < MaxOutstanding; e++) begin
            if (tbl_valid_q[e] && (tbl_id_q[e] == b_id_i)
                && (!b_match || (tbl_age_q[e] < tbl_age_q[b_idx]))) begin
                b_match = 1'b1;
                b_idx   = PtrW'(e);
            end
        end
        b_port    = tbl_port_q[b_idx];
        b_valid_o = '0;
        b_ready_o = b_valid_i;
        if (b_match) begin
            b_valid_o[b_port] = b_valid_i;
            b_ready_o         = b_ready_i[b_port];
        end
        b_free = b_match & b_valid_i & b_ready_i[b_port];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_valid_q   <= '0;
            tbl_cnt_q     <= '0;
            b_unmatched_q <= 1'b0;
            for (int e = 0; e < MaxOutstanding; e++) begin
                tbl_id_q[e]   <= '0;
                tbl_port_q[e] <= '0;
                tbl_age_q[e]  <= '0;
            end
        end else begin
            if (b_free) begin
                tbl_valid_q[b_idx] <= 1'b0;
                for (int e = 0; e < MaxOutstanding; e++)
                    if (tbl_valid_q[e] && (tbl_age_q[e] > tbl_age_q[b_idx]))
                        tbl_age_q[e] <= tbl_age_q[e] - 1'b1;
            end
            if (aw_hs) begin
                tbl_valid_q[alloc_idx] <= 1'b1;
                tbl_id_q[alloc_idx]    <= aw_id_i[int'(aw_sel)*IdWidth +: IdWidth];
                tbl_port_q[alloc_idx]  <= aw_sel;
                tbl_age_q[alloc_idx]   <= PtrW'(tbl_cnt_q - CntW'(b_free));
            end
            tbl_cnt_q     <= tbl_cnt_q + CntW'(aw_hs) - CntW'(b_free);
            b_unmatched_q <= b_valid_i & !b_match;
        end
    end
endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Directed bench for axi_wr_scheduler (default build): arbitration, lock, stalls, ID conflicts, B routing, reset.
module tb_axi_wr_scheduler;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [2:0]  aw_valid_i, aw_ready_o, w_valid_i, w_last_i, w_ready_o, b_valid_o, b_ready_i;
    logic [11:0] aw_id_i;
    logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, b_valid_i, b_ready_o, b_unmatched_o;
    logic [1:0]  aw_sel_o, w_sel_o;
    logic [3:0]  b_id_i;
    logic [2:0]  outstanding_o;
    logic [19:0] all_out;
    int total = 0;
    int bad = 0;

    axi_wr_scheduler #(.NrPorts(3), .IdWidth(4), .MaxOutstanding(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid_i), .aw_id_i(aw_id_i), .aw_ready_o(aw_ready_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_sel_o(aw_sel_o),
        .w_valid_i(w_valid_i), .w_last_i(w_last_i), .w_ready_o(w_ready_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_sel_o(w_sel_o),
        .b_valid_i(b_valid_i), .b_id_i(b_id_i), .b_ready_o(b_ready_o),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .outstanding_o(outstanding_o), .b_unmatched_o(b_unmatched_o)
    );

    always #5 clk_i = ~clk_i;

    assign all_out = {aw_valid_o, aw_ready_o, aw_sel_o, w_valid_o, w_ready_o, w_sel_o,
                      b_valid_o, b_ready_o, outstanding_o, b_unmatched_o};

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        aw_valid_i = '0; aw_id_i = '0; aw_ready_i = 1'b0;
        w_valid_i = '0; w_last_i = '0; w_ready_i = 1'b0;
        b_valid_i = 1'b0; b_id_i = '0; b_ready_i = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        total++;
        if (all_out !== 20'h0) begin
            $display("FAIL reset_outputs got=%h expected=0", all_out); bad++;
        end
        next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0] order [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [3:0] bids [4] = '{4'h0, 4'h8, 4'hC, 4'h0};
        aw_id_i = {4'hC, 4'h8, 4'h0}; aw_valid_i = 3'b111; aw_ready_i = 1'b1;
        w_valid_i = 3'b111; w_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            total++;
            if (aw_valid_o !== 1'b1 || aw_sel_o !== order[i] || aw_ready_o !== (3'b001 << order[i])) begin
                $display("FAIL rr_grant%0d got valid=%b sel=%0d ready=%b expected sel=%0d", i, aw_valid_o, aw_sel_o, aw_ready_o, order[i]); bad++;
            end
            if (i == 0) begin
                total++;
                if (w_valid_o !== 1'b0) begin
                    $display("FAIL rr_w_latency got w_valid_o=%b expected 0", w_valid_o); bad++;
                end
            end
            next_cycle();
        end
        aw_valid_i = '0; w_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_last_i = (i % 2 == 1) ? 3'b111 : 3'b000;
            @(negedge clk_i);
            total++;
            if (w_valid_o !== 1'b1 || w_sel_o !== order[i/2] || w_ready_o !== (3'b001 << order[i/2])) begin
                $display("FAIL rr_w_beat%0d got valid=%b sel=%0d ready=%b expected sel=%0d", i, w_valid_o, w_sel_o, w_ready_o, order[i/2]); bad++;
            end
            next_cycle();
        end
        w_valid_i = '0; w_last_i = '0; w_ready_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (outstanding_o !== 3'd4) begin
            $display("FAIL rr_outstanding got=%0d expected=4", outstanding_o); bad++;
        end
        next_cycle();
        b_valid_i = 1'b1; b_ready_i = 3'b111;
        for (int i = 0; i < 4; i++) begin
            b_id_i = bids[i];
            @(negedge clk_i);
            total++;
            if (b_valid_o !== (3'b001 << order[i]) || b_ready_o !== 1'b1) begin
                $display("FAIL rr_b%0d got b_valid_o=%b b_ready_o=%b expected port %0d", i, b_valid_o, b_ready_o, order[i]); bad++;
            end
            next_cycle();
        end
        b_valid_i = 1'b0; b_ready_i = '0;
        @(negedge clk_i);
        total++;
        if (outstanding_o !== 3'd0) begin
            $display("FAIL rr_drained got=%0d expected=0", outstanding_o); bad++;
        end
        next_cycle();
    endtask

    task automatic test_full_stall();
        logic [3:0] ids [4] = '{4'h2, 4'h3, 4'h4, 4'h6};
        logic [3:0] rel [4] = '{4'h2, 4'h4, 4'h6, 4'h7};
        aw_valid_i = 3'b001; aw_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            aw_id_i = {8'h00, ids[i]};
            @(negedge clk_i);
            total++;
            if (aw_valid_o !== 1'b1 || aw_ready_o !== 3'b001) begin
                $display("FAIL full_fill%0d got valid=%b ready=%b expected 1/001", i, aw_valid_o, aw_ready_o); bad++;
            end
            next_cycle();
        end
        aw_id_i = 12'h007;
        @(negedge clk_i);
        total++;
        if (aw_valid_o !== 1'b0 || aw_ready_o !== 3'b000 || outstanding_o !== 3'd4) begin
            $display("FAIL full_stall got valid=%b ready=%b outstanding=%0d expected 0/000/4", aw_valid_o, aw_ready_o, outstanding_o); bad++;
        end
        next_cycle();
        w_valid_i = 3'b001; w_last_i = 3'b001; w_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            total++;
            if (w_valid_o !== 1'b1 || w_sel_o !== 2'd0 || aw_valid_o !== 1'b0) begin
                $display("FAIL full_w%0d got w_valid=%b w_sel=%0d aw_valid=%b expected 1/0/0", i, w_valid_o, w_sel_o, aw_valid_o); bad++;
            end
            next_cycle();
        end
        w_valid_i = '0; w_last_i = '0; w_ready_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (aw_valid_o !== 1'b0 || outstanding_o !== 3'd4) begin
            $display("FAIL full_table_only got aw_valid=%b outstanding=%0d expected 0/4", aw_valid_o, outstanding_o); bad++;
        end
        next_cycle();
        b_id_i = 4'h3; b_valid_i = 1'b1; b_ready_i = 3'b001;
        @(negedge clk_i);
        total++;
        if (b_valid_o !== 3'b001 || aw_valid_o !== 1'b0) begin
            $display("FAIL full_release_cycle got b_valid_o=%b aw_valid=%b expected 001/0", b_valid_o, aw_valid_o); bad++;
        end
        next_cycle();
        b_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (aw_valid_o !== 1'b1 || aw_sel_o !== 2'd0 || outstanding_o !== 3'd3) begin
            $display("FAIL full_regrant got aw_valid=%b sel=%0d outstanding=%0d expected 1/0/3", aw_valid_o, aw_sel_o, outstanding_o); bad++;
        end
        next_cycle();
        aw_valid_i = '0; aw_ready_i = 1'b0;
        w_valid_i = 3'b001; w_last_i = 3'b001; w_ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (outstanding_o !== 3'd4 || w_valid_o !== 1'b1) begin
            $display("FAIL full_refill got outstanding=%0d w_valid=%b expected 4/1", outstanding_o, w_valid_o); bad++;
        end
        next_cycle();
        w_valid_i = '0; w_last_i = '0; w_ready_i = 1'b0;
        b_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_id_i = rel[i];
            next_cycle();
        end
        b_valid_i = 1'b0; b_ready_i = '0;
        @(negedge clk_i);
        total++;
        if (outstanding_o !== 3'd0) begin
            $display("FAIL full_drained got=%0d expected=0", outstanding_o); bad++;
        end
        next_cycle();
    endtask

    task automatic test_id_conflict();
        aw_id_i = {4'hC, 4'hC, 4'h0}; aw_valid_i = 3'b100; aw_ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (aw_valid_o !== 1'b1 || aw_sel_o !== 2'd2) begin
            $display("FAIL idc_grant2 got valid=%b sel=%0d expected 1/2", aw_valid_o, aw_sel_o); bad++;
        end
        next_cycle();
        aw_valid_i = 3'b010;
        w_valid_i = 3'b100; w_last_i = 3'b100; w_ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (aw_valid_o !== 1'b0 || w_valid_o !== 1'b1 || w_sel_o !== 2'd2) begin
            $display("FAIL idc_blocked got aw_valid=%b w_valid=%b w_sel=%0d expected 0/1/2", aw_valid_o, w_valid_o, w_sel_o); bad++;
        end
        next_cycle();
        w_valid_i = '0; w_last_i = '0; w_ready_i = 1'b0;
        b_id_i = 4'hC; b_valid_i = 1'b1; b_ready_i = 3'b111;
        @(negedge clk_i);
        total++;
        if (b_valid_o !== 3'b100 || aw_valid_o !== 1'b0) begin
            $display("FAIL idc_b_to_port2 got b_valid_o=%b aw_valid=%b expected 100/0", b_valid_o, aw_valid_o); bad++;
        end
        next_cycle();
        b_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (aw_valid_o !== 1'b1 || aw_sel_o !== 2'd1 || aw_ready_o !== 3'b010) begin
            $display("FAIL idc_grant1 got valid=%b sel=%0d ready=%b expected 1/1/010", aw_valid_o, aw_sel_o, aw_ready_o); bad++;
        end
        next_cycle();
        aw_valid_i = '0; aw_ready_i = 1'b0;
        w_valid_i = 3'b010; w_last_i = 3'b010; w_ready_i = 1'b1;
        next_cycle();
        w_valid_i = '0; w_last_i = '0; w_ready_i = 1'b0;
        b_valid_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (b_valid_o !== 3'b010) begin
            $display("FAIL idc_b_to_port1 got b_valid_o=%b expected 010", b_valid_o); bad++;
        end
        next_cycle();
        b_valid_i = 1'b0; b_ready_i = '0;
    endtask

    task automatic test_lock();
        aw_id_i = {4'h0, 4'h9, 4'h1}; aw_valid_i = 3'b010; aw_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) aw_valid_i = 3'b011;
            @(negedge clk_i);
            total++;
            if (aw_valid_o !== 1'b1 || aw_sel_o !== 2'd1 || aw_ready_o !== 3'b000) begin
                $display("FAIL lock_hold%0d got valid=%b sel=%0d ready=%b expected 1/1/000", c, aw_valid_o, aw_sel_o, aw_ready_o); bad++;
            end
            next_cycle();
        end
        aw_ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (aw_sel_o !== 2'd1 || aw_ready_o !== 3'b010) begin
            $display("FAIL lock_release got sel=%0d ready=%b expected 1/010", aw_sel_o, aw_ready_o); bad++;
        end
        next_cycle();
        aw_valid_i = 3'b001;
        @(negedge clk_i);
        total++;
        if (aw_valid_o !== 1'b1 || aw_sel_o !== 2'd0 || aw_ready_o !== 3'b001) begin
            $display("FAIL lock_next got valid=%b sel=%0d ready=%b expected 1/0/001", aw_valid_o, aw_sel_o, aw_ready_o); bad++;
        end
        next_cycle();
        aw_valid_i = '0; aw_ready_i = 1'b0;
        w_valid_i = 3'b111; w_last_i = 3'b111; w_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            total++;
            if (w_sel_o !== ((i == 0) ? 2'd1 : 2'd0)) begin
                $display("FAIL lock_w%0d got w_sel=%0d expected %0d", i, w_sel_o, (i == 0) ? 1 : 0); bad++;
            end
            next_cycle();
        end
        w_valid_i = '0; w_last_i = '0; w_ready_i = 1'b0;
    endtask

    task automatic test_b_routing();
        b_id_i = 4'h9; b_valid_i = 1'b1; b_ready_i = 3'b101;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            total++;
            if (b_valid_o !== 3'b010 || b_ready_o !== 1'b0) begin
                $display("FAIL b_hold%0d got b_valid_o=%b b_ready_o=%b expected 010/0", c, b_valid_o, b_ready_o); bad++;
            end
            next_cycle();
        end
        b_ready_i = 3'b111;
        @(negedge clk_i);
        total++;
        if (b_valid_o !== 3'b010 || b_ready_o !== 1'b1) begin
            $display("FAIL b_accept got b_valid_o=%b b_ready_o=%b expected 010/1", b_valid_o, b_ready_o); bad++;
        end
        next_cycle();
        b_id_i = 4'h5;
        @(negedge clk_i);
        total++;
        if (b_valid_o !== 3'b000 || b_ready_o !== 1'b1 || b_unmatched_o !== 1'b0) begin
            $display("FAIL b_unmatched_drop got b_valid_o=%b b_ready_o=%b pulse=%b expected 000/1/0", b_valid_o, b_ready_o, b_unmatched_o); bad++;
        end
        next_cycle();
        b_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (b_unmatched_o !== 1'b1) begin
            $display("FAIL b_unmatched_pulse got=%b expected=1", b_unmatched_o); bad++;
        end
        next_cycle();
        @(negedge clk_i);
        total++;
        if (b_unmatched_o !== 1'b0 || outstanding_o !== 3'd1) begin
            $display("FAIL b_pulse_end got pulse=%b outstanding=%0d expected 0/1", b_unmatched_o, outstanding_o); bad++;
        end
        next_cycle();
        b_id_i = 4'h1; b_valid_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (b_valid_o !== 3'b001) begin
            $display("FAIL b_port0 got b_valid_o=%b expected 001", b_valid_o); bad++;
        end
        next_cycle();
        b_valid_i = 1'b0; b_ready_i = '0;
    endtask

    task automatic test_reset_mid_burst();
        aw_id_i = {4'h3, 4'h2, 4'h5}; aw_valid_i = 3'b001; aw_ready_i = 1'b1;
        next_cycle();
        aw_valid_i = '0;
        w_valid_i = 3'b001; w_last_i = 3'b000; w_ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (w_valid_o !== 1'b1 || outstanding_o !== 3'd1) begin
            $display("FAIL rst_pre got w_valid=%b outstanding=%0d expected 1/1", w_valid_o, outstanding_o); bad++;
        end
        next_cycle();
        rst_ni = 1'b0;
        #1;
        total++;
        if (all_out !== 20'h0) begin
            $display("FAIL rst_mid_outputs got=%h expected=0", all_out); bad++;
        end
        next_cycle();
        rst_ni = 1'b1;
        w_valid_i = '0; w_ready_i = 1'b0;
        aw_valid_i = 3'b111;
        @(negedge clk_i);
        total++;
        if (aw_valid_o !== 1'b1 || aw_sel_o !== 2'd0 || aw_ready_o !== 3'b001 || outstanding_o !== 3'd0) begin
            $display("FAIL rst_fresh_grant got valid=%b sel=%0d ready=%b outstanding=%0d expected 1/0/001/0", aw_valid_o, aw_sel_o, aw_ready_o, outstanding_o); bad++;
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_full_stall();
        test_id_conflict();
        test_lock();
        test_b_routing();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
